// File: rtl/pc_pkg.sv
// Shared defaults and the redirect-select encoding for the fetch program counter.
package pc_pkg;

  localparam int unsigned XLEN_DEF       = 32;
  localparam logic [31:0] RESET_PC_DEF   = 32'h0000_0000;
  localparam logic [31:0] EXC_VECTOR_DEF = 32'h0000_0180;
  localparam int unsigned RAS_DEPTH_DEF  = 4;

  // Next-pc source, listed highest priority first.
  typedef enum logic [2:0] {
    SEL_EXC = 3'd0,
    SEL_JR  = 3'd1,
    SEL_JMP = 3'd2,
    SEL_BR  = 3'd3,
    SEL_SEQ = 3'd4
  } pc_sel_e;

endpackage

// File: rtl/pc_if.sv
// Control/redirect inputs and fetch-address outputs of pc_unit.
// i_* are driven by decode/execute (master) into pc_unit (slave);
// o_* are the fetch address, handshake valid, error pulse and RAS status.
interface pc_if import pc_pkg::*; #(
  parameter int unsigned XLEN      = XLEN_DEF,
  parameter int unsigned RAS_DEPTH = RAS_DEPTH_DEF
);
  localparam int unsigned CW = $clog2(RAS_DEPTH + 1);

  logic            i_fetch_ready;
  logic            i_stall;
  logic            i_br_taken;
  logic [15:0]     i_br_offset;
  logic            i_jump;
  logic            i_jal;
  logic [25:0]     i_instr_index;
  logic            i_jr;
  logic [XLEN-1:0] i_jr_target;
  logic            i_exc;
  logic            o_pc_valid;
  logic [XLEN-1:0] o_pc;
  logic            o_addr_err;
  logic [XLEN-1:0] o_ras_top;
  logic            o_ras_empty;
  logic [CW-1:0]   o_ras_count;

  modport master (
    output i_fetch_ready, i_stall, i_br_taken, i_br_offset, i_jump, i_jal,
           i_instr_index, i_jr, i_jr_target, i_exc,
    input  o_pc_valid, o_pc, o_addr_err, o_ras_top, o_ras_empty, o_ras_count
  );

  modport slave (
    input  i_fetch_ready, i_stall, i_br_taken, i_br_offset, i_jump, i_jal,
           i_instr_index, i_jr, i_jr_target, i_exc,
    output o_pc_valid, o_pc, o_addr_err, o_ras_top, o_ras_empty, o_ras_count
  );

endinterface

// File: rtl/ras_stack.sv
// Circular return-address stack with saturating occupancy count.
// Ports: i_clk, i_rst (async active-low), i_push/i_pop/i_clr strobes,
//        i_din push data, o_top newest entry (0 when empty), o_count live entries.
module ras_stack #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned RAS_DEPTH = 4
) (
  input  logic                             i_clk,
  input  logic                             i_rst,
  input  logic                             i_push,
  input  logic                             i_pop,
  input  logic                             i_clr,
  input  logic [XLEN-1:0]                  i_din,
  output logic [XLEN-1:0]                  o_top,
  output logic [$clog2(RAS_DEPTH+1)-1:0]   o_count
);

  localparam int unsigned CW = $clog2(RAS_DEPTH + 1);
  localparam int unsigned PW = $clog2(RAS_DEPTH);

  logic [XLEN-1:0] r_mem [RAS_DEPTH];
  logic [PW-1:0]   r_wptr;
  logic [CW-1:0]   r_count;
  logic [PW-1:0]   w_wptr_inc;
  logic [PW-1:0]   w_wptr_dec;

  // r_wptr is the next write slot; the newest entry sits one behind it.
  always_comb begin
    w_wptr_inc = (r_wptr == PW'(RAS_DEPTH - 1)) ? '0 : r_wptr + PW'(1);
    w_wptr_dec = (r_wptr == '0) ? PW'(RAS_DEPTH - 1) : r_wptr - PW'(1);
  end

  // Push on full overwrites the oldest slot, so the count just saturates.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_wptr  <= '0;
      r_count <= '0;
      for (int i = 0; i < int'(RAS_DEPTH); i++) r_mem[i] <= '0;
    end else if (i_clr) begin
      r_wptr  <= '0;
      r_count <= '0;
    end else if (i_push) begin
      r_mem[r_wptr] <= i_din;
      r_wptr        <= w_wptr_inc;
      if (r_count != CW'(RAS_DEPTH)) r_count <= r_count + CW'(1);
    end else if (i_pop && (r_count != '0)) begin
      r_wptr  <= w_wptr_dec;
      r_count <= r_count - CW'(1);
    end
  end

  assign o_top   = (r_count == '0) ? '0 : r_mem[w_wptr_dec];
  assign o_count = r_count;

endmodule

// File: rtl/pc_unit.sv
// MIPS fetch-stage program counter: valid/ready fetch handshake, stall hold,
// exception redirect, prioritised JR / J / JAL / branch redirects and a RAS.
// Ports: clk, rst (async active-low), bus (pc_if.slave: redirect controls in,
//        pc / pc_valid / addr_err / RAS status out).
module pc_unit import pc_pkg::*; #(
  parameter int unsigned XLEN       = XLEN_DEF,
  parameter logic [31:0] RESET_PC   = RESET_PC_DEF,
  parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEF,
  parameter int unsigned RAS_DEPTH  = RAS_DEPTH_DEF
) (
  input  logic clk,
  input  logic rst,
  pc_if.slave  bus
);

  localparam logic [XLEN-1:0] RESET_PC_X   = XLEN'(RESET_PC);
  localparam logic [XLEN-1:0] EXC_VECTOR_X = XLEN'(EXC_VECTOR);

  logic            r_pc_valid;
  logic [XLEN-1:0] r_pc;
  logic            r_addr_err;

  logic            w_adv;
  logic            w_load;
  pc_sel_e         w_sel;
  logic [XLEN-1:0] w_pc4;
  logic [XLEN-1:0] w_pc8;
  logic [XLEN-1:0] w_br_off;
  logic [XLEN-1:0] w_pc_nxt;
  logic            w_push;
  logic            w_pop;
  logic            w_clr;
  logic [XLEN-1:0] w_ras_top;

  // Exceptions bypass the handshake; everything else waits for an accepted fetch.
  assign w_adv  = r_pc_valid & bus.i_fetch_ready & ~bus.i_stall;
  assign w_load = r_pc_valid & (bus.i_exc | w_adv);

  assign w_pc4    = r_pc + XLEN'(4);
  assign w_pc8    = r_pc + XLEN'(8);
  assign w_br_off = {{(XLEN-18){bus.i_br_offset[15]}}, bus.i_br_offset, 2'b00};

  // Priority select and next-pc mux.
  always_comb begin
    w_sel    = SEL_SEQ;
    w_pc_nxt = w_pc4;
    if (bus.i_exc)                     w_sel = SEL_EXC;
    else if (bus.i_jr)                 w_sel = SEL_JR;
    else if (bus.i_jump || bus.i_jal)  w_sel = SEL_JMP;
    else if (bus.i_br_taken)           w_sel = SEL_BR;
    case (w_sel)
      SEL_EXC: w_pc_nxt = EXC_VECTOR_X;
      SEL_JR:  w_pc_nxt = {bus.i_jr_target[XLEN-1:2], 2'b00};
      SEL_JMP: w_pc_nxt = {w_pc4[XLEN-1:28], bus.i_instr_index, 2'b00};
      SEL_BR:  w_pc_nxt = w_pc4 + w_br_off;
      default: w_pc_nxt = w_pc4;
    endcase
  end

  // Push and pop are mutually exclusive by construction of w_sel.
  assign w_clr  = r_pc_valid & bus.i_exc;
  assign w_push = w_load & (w_sel == SEL_JMP) & bus.i_jal;
  assign w_pop  = w_load & (w_sel == SEL_JR);

  // pc_valid rises on the first edge after reset; pc moves only on w_load.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pc       <= RESET_PC_X;
      r_pc_valid <= 1'b0;
      r_addr_err <= 1'b0;
    end else begin
      r_pc_valid <= 1'b1;
      r_addr_err <= w_pop & (|bus.i_jr_target[1:0]);
      if (w_load) r_pc <= w_pc_nxt;
    end
  end

  ras_stack #(
    .XLEN      (XLEN),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_clr   (w_clr),
    .i_din   (w_pc8),
    .o_top   (w_ras_top),
    .o_count (bus.o_ras_count)
  );

  assign bus.o_pc        = r_pc;
  assign bus.o_pc_valid  = r_pc_valid;
  assign bus.o_addr_err  = r_addr_err;
  assign bus.o_ras_top   = w_ras_top;
  assign bus.o_ras_empty = (bus.o_ras_count == '0);

endmodule

// File: tb/tb_pc_unit.sv
// Directed bench for pc_unit: reset, sequential fetch, branch/stall,
// J/JAL/JR with RAS, RAS overflow, exception priority, wrap and async reset.
module tb_pc_unit;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  pc_if #(.XLEN(32), .RAS_DEPTH(4)) bus ();

  pc_unit #(
    .XLEN       (32),
    .RESET_PC   (32'h0000_0000),
    .EXC_VECTOR (32'h0000_0180),
    .RAS_DEPTH  (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock edge and settle past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    bus.i_stall       = 1'b0;
    bus.i_br_taken    = 1'b0;
    bus.i_br_offset   = 16'h0;
    bus.i_jump        = 1'b0;
    bus.i_jal         = 1'b0;
    bus.i_instr_index = 26'h0;
    bus.i_jr          = 1'b0;
    bus.i_jr_target   = 32'h0;
    bus.i_exc         = 1'b0;
  endtask

  task automatic do_jal(input logic [25:0] idx);
    bus.i_jal = 1'b1; bus.i_instr_index = idx;
    step();
    idle_in();
  endtask

  task automatic do_jr(input logic [31:0] tgt);
    bus.i_jr = 1'b1; bus.i_jr_target = tgt;
    step();
    idle_in();
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst = 1'b0;
    bus.i_fetch_ready = 1'b1;
    idle_in();

    // Reset state
    #2;
    check("rst_valid", 64'(bus.o_pc_valid), 64'h0);
    check("rst_pc",    64'(bus.o_pc), 64'h0);
    check("rst_cnt",   64'(bus.o_ras_count), 64'h0);
    check("rst_empty", 64'(bus.o_ras_empty), 64'h1);
    check("rst_top",   64'(bus.o_ras_top), 64'h0);
    check("rst_aerr",  64'(bus.o_addr_err), 64'h0);
    step();
    check("hold_valid", 64'(bus.o_pc_valid), 64'h0);
    rst = 1'b1;

    // Sequential fetch 0,0(valid),4,8,C
    step();
    check("first_valid", 64'(bus.o_pc_valid), 64'h1);
    check("first_pc",    64'(bus.o_pc), 64'h0);
    step(); check("seq_4", 64'(bus.o_pc), 64'h4);
    step(); check("seq_8", 64'(bus.o_pc), 64'h8);
    step(); check("seq_c", 64'(bus.o_pc), 64'hC);

    // J to 0x40
    bus.i_jump = 1'b1; bus.i_instr_index = 26'h10;
    step(); idle_in();
    check("j_40", 64'(bus.o_pc), 64'h40);

    // Branch with stall holds, then taken: 0x44 - 8 = 0x3C
    bus.i_br_taken = 1'b1; bus.i_br_offset = 16'hFFFE; bus.i_stall = 1'b1;
    step();
    check("br_stall", 64'(bus.o_pc), 64'h40);
    bus.i_stall = 1'b0;
    step(); idle_in();
    check("br_back", 64'(bus.o_pc), 64'h3C);

    // fetch_ready low holds pc
    bus.i_fetch_ready = 1'b0; bus.i_jump = 1'b1; bus.i_instr_index = 26'h400;
    step();
    check("nordy_hold", 64'(bus.o_pc), 64'h3C);
    bus.i_fetch_ready = 1'b1;
    step(); idle_in();
    check("j_1000", 64'(bus.o_pc), 64'h1000);

    // JAL from 0x1000 then JR back
    do_jal(26'h100);
    check("jal_pc",  64'(bus.o_pc), 64'h400);
    check("jal_top", 64'(bus.o_ras_top), 64'h1008);
    check("jal_cnt", 64'(bus.o_ras_count), 64'h1);
    do_jr(32'h1008);
    check("jr_pc",    64'(bus.o_pc), 64'h1008);
    check("jr_empty", 64'(bus.o_ras_empty), 64'h1);
    check("jr_aerr",  64'(bus.o_addr_err), 64'h0);

    // Five pushes: A=0x1010 B=0x408 C=0x808 D=0xC08 E=0x1008
    do_jal(26'h100); check("p1_pc", 64'(bus.o_pc), 64'h400);
    do_jal(26'h200);
    do_jal(26'h300);
    do_jal(26'h400);
    check("p4_top", 64'(bus.o_ras_top), 64'hC08);
    do_jal(26'h500);
    check("p5_pc",  64'(bus.o_pc), 64'h1400);
    check("ovf_cnt", 64'(bus.o_ras_count), 64'h4);
    check("ovf_top", 64'(bus.o_ras_top), 64'h1008);
    do_jr(32'h2000);
    check("pop1_top", 64'(bus.o_ras_top), 64'hC08);
    check("pop1_cnt", 64'(bus.o_ras_count), 64'h3);
    do_jr(32'h2000);
    check("pop2_top", 64'(bus.o_ras_top), 64'h808);
    do_jr(32'h2000);
    check("pop3_top", 64'(bus.o_ras_top), 64'h408);
    do_jr(32'h2000);
    check("pop4_empty", 64'(bus.o_ras_empty), 64'h1);
    check("pop4_top",   64'(bus.o_ras_top), 64'h0);
    do_jr(32'h2000);
    check("pop5_cnt", 64'(bus.o_ras_count), 64'h0);
    check("pop5_pc",  64'(bus.o_pc), 64'h2000);

    // Exception beats stall and jr/jal and clears RAS
    do_jal(26'h100);
    check("pre_exc_cnt", 64'(bus.o_ras_count), 64'h1);
    bus.i_exc = 1'b1; bus.i_stall = 1'b1; bus.i_jr = 1'b1; bus.i_jal = 1'b1;
    bus.i_jr_target = 32'h3000;
    step(); idle_in();
    check("exc_pc",  64'(bus.o_pc), 64'h180);
    check("exc_cnt", 64'(bus.o_ras_count), 64'h0);

    // Misaligned JR: aligned pc and a single-cycle error pulse
    do_jr(32'h2002);
    check("mis_pc",   64'(bus.o_pc), 64'h2000);
    check("mis_aerr", 64'(bus.o_addr_err), 64'h1);
    step();
    check("mis_aerr_clr", 64'(bus.o_addr_err), 64'h0);
    check("mis_seq", 64'(bus.o_pc), 64'h2004);

    // Wrap at top of address space
    do_jr(32'hFFFF_FFFC);
    check("top_pc", 64'(bus.o_pc), 64'hFFFF_FFFC);
    step();
    check("wrap_0", 64'(bus.o_pc), 64'h0);

    // Jump outranks branch in the same cycle
    bus.i_jump = 1'b1; bus.i_instr_index = 26'h40;
    bus.i_br_taken = 1'b1; bus.i_br_offset = 16'h0005;
    step(); idle_in();
    check("j_over_br", 64'(bus.o_pc), 64'h100);

    // Async reset mid-stream
    do_jal(26'h80);
    check("pre_rst_cnt", 64'(bus.o_ras_count), 64'h1);
    #2;
    rst = 1'b0;
    #1;
    check("arst_pc",    64'(bus.o_pc), 64'h0);
    check("arst_valid", 64'(bus.o_pc_valid), 64'h0);
    check("arst_cnt",   64'(bus.o_ras_count), 64'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
